// File: rtl/ha_2.sv
// ha_2: half adder with a combinational path (Su/Ca) and a registered,
// valid-qualified path (Su_q/Ca_q/out_valid) plus two saturating counters
// tracking accepted pairs and accepted pairs that produced a carry.
module ha_2 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             in_valid,
  output logic             Su,
  output logic             Ca,
  output logic             Su_q,
  output logic             Ca_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic sum_d;
  logic carry_d;

  // Pure half-adder logic; no dependence on clk, rst or in_valid, so it
  // keeps working with the clock stopped or the block held in reset.
  always_comb begin
    sum_d   = A ^ B;
    carry_d = A & B;
  end

  assign Su = sum_d;
  assign Ca = carry_d;

  // Registered path and statistics: capture each accepted pair, flag it for
  // one cycle, and count it without ever wrapping.
  // NOTE: reset is synchronous here, so it lives inside the clocked branch
  // and wins over in_valid on the same edge; all state uses <= so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      Su_q       <= 1'b0;
      Ca_q       <= 1'b0;
      out_valid  <= 1'b0;
      sample_cnt <= '0;
      carry_cnt  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Su_q <= sum_d;
        Ca_q <= carry_d;
        if (sample_cnt != CNT_MAX) begin
          sample_cnt <= sample_cnt + CNT_ONE;
        end
        // carry_cnt only moves on an accepted pair, so it can never
        // overtake sample_cnt; both stop at the same ceiling.
        if (carry_d && (carry_cnt != CNT_MAX)) begin
          carry_cnt <= carry_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ha_2.sv
// tb_ha_2: scoreboard bench for ha_2. Two instances share all inputs: one
// with the default counter width and one with CNT_W = 2 to reach
// saturation quickly. The driver updates a behavioural model and pushes the
// expected post-edge state; an independent monitor pops and compares.
module tb_ha_2;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic        A;
  logic        B;
  logic        in_valid;

  logic        su_w16, ca_w16, su_q_w16, ca_q_w16, ov_w16;
  logic [15:0] sc_w16, cc_w16;
  logic        su_w2, ca_w2, su_q_w2, ca_q_w2, ov_w2;
  logic [1:0]  sc_w2, cc_w2;

  ha_2 #(.CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid),
    .Su(su_w16), .Ca(ca_w16), .Su_q(su_q_w16), .Ca_q(ca_q_w16),
    .out_valid(ov_w16), .sample_cnt(sc_w16), .carry_cnt(cc_w16)
  );

  ha_2 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid),
    .Su(su_w2), .Ca(ca_w2), .Su_q(su_q_w2), .Ca_q(ca_q_w2),
    .out_valid(ov_w2), .sample_cnt(sc_w2), .carry_cnt(cc_w2)
  );

  typedef struct packed {
    logic        su_q;
    logic        ca_q;
    logic        ov;
    logic [31:0] sc16;
    logic [31:0] cc16;
    logic [31:0] sc2;
    logic [31:0] cc2;
  } exp_t;

  // Half-adder truth table indexed by {A,B}, giving {Ca,Su}.
  localparam logic [1:0] TT [4] = '{2'b00, 2'b01, 2'b01, 2'b10};

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state (written only by the driver).
  logic m_su, m_ca, m_ov;
  int   m_sc16, m_cc16, m_sc2, m_cc2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : max;
  endfunction

  // Present one cycle of stimulus and queue the state expected after the edge.
  task automatic drive(input logic a, input logic b, input logic v, input logic r);
    exp_t e;
    @(negedge clk);
    A = a; B = b; in_valid = v; rst = r;
    if (r) begin
      m_su = 1'b0; m_ca = 1'b0; m_ov = 1'b0;
      m_sc16 = 0; m_cc16 = 0; m_sc2 = 0; m_cc2 = 0;
    end else begin
      m_ov = v;
      if (v) begin
        m_su   = (a + b) % 2 == 1;
        m_ca   = (a + b) == 2;
        m_sc16 = sat_inc(m_sc16, 65535);
        m_sc2  = sat_inc(m_sc2, 3);
        if (m_ca) begin
          m_cc16 = sat_inc(m_cc16, 65535);
          m_cc2  = sat_inc(m_cc2, 3);
        end
      end
    end
    e.su_q = m_su; e.ca_q = m_ca; e.ov = m_ov;
    e.sc16 = m_sc16; e.cc16 = m_cc16; e.sc2 = m_sc2; e.cc2 = m_cc2;
    sb.push_back(e);
  endtask

  // Clock starts only after the clockless combinational check.
  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  // Monitor: after every rising edge, compare the DUTs with the oldest
  // queued expectation; also track the combinational outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("su_q16", su_q_w16, e.su_q);
        check("ca_q16", ca_q_w16, e.ca_q);
        check("ov16",   ov_w16,   e.ov);
        check("sc16",   sc_w16,   e.sc16);
        check("cc16",   cc_w16,   e.cc16);
        check("su_q2",  su_q_w2,  e.su_q);
        check("ca_q2",  ca_q_w2,  e.ca_q);
        check("ov2",    ov_w2,    e.ov);
        check("sc2",    sc_w2,    e.sc2);
        check("cc2",    cc_w2,    e.cc2);
        check("cnt_order16", cc_w16 <= sc_w16, 1);
        check("comb16", {ca_w16, su_w16}, TT[{A, B}]);
        check("comb2",  {ca_w2,  su_w2},  TT[{A, B}]);
      end else if (ov_w16 === 1'b1) begin
        check("ov_unexpected", ov_w16, 0);
      end
    end
  end

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] ab;
    clk_en = 1'b0; rst = 1'b1; in_valid = 1'b0; A = 1'b0; B = 1'b0;

    // Combinational truth table with no clock running.
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      {A, B} = ab;
      #1;
      check("comb_noclk16", {ca_w16, su_w16}, TT[i]);
      check("comb_noclk2",  {ca_w2,  su_w2},  TT[i]);
    end

    clk_en = 1'b1;

    // Reset, then a single accepted 1+1 and two idle cycles (hold).
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    drive(1, 1, 1, 0);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);

    // Back-to-back stream 00, 01, 10, 11.
    drive(0, 0, 1, 0);
    drive(0, 1, 1, 0);
    drive(1, 0, 1, 0);
    drive(1, 1, 1, 0);

    // Idle while A/B toggle.
    for (int i = 0; i < 5; i++) drive(1'($urandom), 1'($urandom), 0, 0);

    // Saturation from a clean start.
    drive(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) drive(1, 1, 1, 0);
    @(posedge clk);
    #2;
    check("sat_sample2", sc_w2, 3);
    check("sat_carry2",  cc_w2, 3);
    check("nosat_sample16", sc_w16, 6);

    // Reset mid-stream while a valid 1+1 is presented.
    drive(1, 0, 1, 0);
    drive(1, 1, 1, 1);
    #2;
    check("reset_ca_comb", ca_w16, 1);
    drive(0, 1, 1, 0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 39) == 0));
    end

    drive(0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
